// File: rtl/ps2_pkg.sv
// Shared frame layout constants and parity helper for the PS/2 receive path.
package ps2_pkg;

  localparam int FRAME_BITS = 11;
  localparam int START_IDX  = 0;
  localparam int PARITY_IDX = 9;
  localparam int STOP_IDX   = 10;
  localparam int DATA_W     = 8;

  typedef logic [FRAME_BITS-1:0] frame_t;

  // Parity bit that makes the total count of ones across byte+parity odd.
  function automatic logic odd_parity(input logic [DATA_W-1:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Synchronous byte FIFO with extra-MSB pointers; head is a combinational read.
module ps2_byte_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronise, detect falling edges, deframe and
// check start/parity/stop, then queue good bytes for the downstream consumer.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        nextdata_n,
  output logic [7:0]  data,
  output logic        ready,
  output logic        overflow,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic [3:0]             bit_cnt;
  logic [TW-1:0]          tcnt;
  logic [FRAME_BITS-2:0]  shreg;
  logic                   err_p1;

  logic                   fall_p0;
  logic                   bit_p0;
  logic                   last_p0;
  logic                   good_p0;
  logic                   timeout_p0;
  frame_t                 frame_p0;
  logic                   push;
  logic                   pop;
  logic                   empty;
  logic                   full;

  // p0: edge detect and same-cycle frame evaluation on the final bit
  assign fall_p0    = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
  assign bit_p0     = dat_sync[SYNC_STAGES-1];
  assign frame_p0   = {bit_p0, shreg};
  assign last_p0    = fall_p0 && (bit_cnt == 4'(STOP_IDX));
  assign good_p0    = !frame_p0[START_IDX] && frame_p0[STOP_IDX] &&
                      (frame_p0[PARITY_IDX] == odd_parity(frame_p0[PARITY_IDX-1:START_IDX+1]));
  assign timeout_p0 = !fall_p0 && (bit_cnt != 4'd0) && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign push       = last_p0 && good_p0;
  assign pop        = !nextdata_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      bit_cnt  <= '0;
      tcnt     <= '0;
      err_p1   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      err_p1   <= (last_p0 && !good_p0) || timeout_p0;
      if (fall_p0) begin
        tcnt    <= '0;
        bit_cnt <= last_p0 ? 4'd0 : bit_cnt + 4'd1;
      end else if (bit_cnt != 4'd0) begin
        if (timeout_p0) begin
          bit_cnt <= '0;
          tcnt    <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
      // Full implies non-empty, so only an actual pop request can make room.
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fall_p0) shreg <= frame_p0[FRAME_BITS-1:1];
  end

  // p1: registered error pulse
  assign frame_err = err_p1;
  assign ready     = !empty;

  ps2_byte_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (frame_p0[PARITY_IDX-1:START_IDX+1]),
    .head  (data),
    .empty (empty),
    .full  (full)
  );

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: directed frames plus randomized traffic against a queue-based model.
module tb_ps2_rx;

  localparam int DEPTH = 8;
  localparam int TO    = 5000;
  localparam int SS    = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       pop_req_n = 1'b1;
  logic       rnd_n = 1'b1;
  logic       rnd_pop = 1'b0;
  logic       chk_en = 1'b0;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  assign nextdata_n = rnd_pop ? rnd_n : pop_req_n;

  ps2_rx #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO),
    .SYNC_STAGES    (SS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: inputs seen after the synchroniser delay, bits collected
  // into a list, frames judged by counting ones, bytes held in a bounded queue.
  bit         mh_c [SS];
  bit         mh_d [SS];
  int         mbits [$];
  int         mt;
  logic [7:0] mq [$];
  bit         movf;
  bit         merr;
  int         mpushes;

  always @(posedge clk) begin : model
    bit fall, b, popped, full, err_n;
    int v, ones;
    fall  = mh_c[SS-1] && !mh_c[SS-2];
    b     = mh_d[SS-1];
    err_n = 1'b0;
    if (rst) begin
      for (int i = 0; i < SS; i++) begin
        mh_c[i] = 1'b1;
        mh_d[i] = 1'b1;
      end
      mbits.delete();
      mq.delete();
      mt = 0; movf = 1'b0; merr = 1'b0; mpushes = 0;
    end else begin
      popped = (nextdata_n == 1'b0) && (mq.size() > 0);
      full   = (mq.size() == DEPTH);
      if (popped) void'(mq.pop_front());
      if (fall) begin
        mt = 0;
        mbits.push_back(int'(b));
        if (mbits.size() == 11) begin
          v = 0;
          ones = 0;
          for (int i = 0; i < 8; i++) v = v | (mbits[1+i] << i);
          for (int i = 1; i <= 9; i++) ones = ones + mbits[i];
          if (mbits[0] == 0 && mbits[10] == 1 && (ones % 2) == 1) begin
            if (full && !popped) movf = 1'b1;
            else begin
              mq.push_back(v[7:0]);
              mpushes++;
            end
          end else begin
            err_n = 1'b1;
          end
          mbits.delete();
        end
      end else if (mbits.size() > 0) begin
        if (mt == TO - 1) begin
          mbits.delete();
          mt = 0;
          err_n = 1'b1;
        end else begin
          mt++;
        end
      end
      merr = err_n;
      for (int i = SS - 1; i > 0; i--) begin
        mh_c[i] = mh_c[i-1];
        mh_d[i] = mh_d[i-1];
      end
      mh_c[0] = ps2_clk;
      mh_d[0] = ps2_data;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", ready, mq.size() != 0);
      check("overflow", overflow, movf);
      check("frame_err", frame_err, merr);
      if (mq.size() != 0) check("data", data, mq[0]);
      else if (mpushes == 0) check("data_idle", data, 8'h00);
    end
    if (frame_err === 1'b1) err_seen++;
    rnd_n = ($urandom_range(0, 3) != 0);
  end

  function automatic logic [10:0] mk(input logic [7:0] b, input int kind);
    logic p, st, sb;
    p  = ~^b;
    st = 1'b1;
    sb = 1'b0;
    if (kind == 1) p = ~p;
    if (kind == 2) st = 1'b0;
    if (kind == 3) sb = 1'b1;
    return {st, p, b, sb};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int nb, input int hp);
    for (int i = 0; i < nb; i++) begin
      @(negedge clk); ps2_data = f[i];
      repeat (hp) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (hp) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk); ps2_data = 1'b1;
  endtask

  task automatic do_pop();
    pop_req_n = 1'b0;
    @(negedge clk);
    pop_req_n = 1'b1;
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) check("wait_ready_timeout", ready, 1'b1);
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst_ready", ready, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_data", data, 8'h00);
  endtask

  initial begin
    int kind, hp;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_ready", ready, 1'b0);
    check("reset_data", data, 8'h00);
    rst = 1'b0;

    // Single frame 0x1C
    err_seen = 0;
    send_bits(mk(8'h1C, 0), 11, 10);
    repeat (5) @(negedge clk);
    check("t1_data", data, 8'h1C);
    check("t1_ready", ready, 1'b1);
    check("t1_no_err", err_seen, 0);
    do_pop();

    // Back-to-back F0, 1C with pops on first ready cycle
    fork
      begin
        send_bits(mk(8'hF0, 0), 11, 10);
        send_bits(mk(8'h1C, 0), 11, 10);
      end
      begin
        wait_ready(3000);
        check("t2_first", data, 8'hF0);
        do_pop();
        wait_ready(3000);
        check("t2_second", data, 8'h1C);
        do_pop();
      end
    join
    repeat (2) @(negedge clk);
    check("t2_empty", ready, 1'b0);

    // Bad parity, then bad stop
    repeat (5) @(negedge clk);
    err_seen = 0;
    send_bits(mk(8'h1C, 1), 11, 10);
    repeat (5) @(negedge clk);
    check("t3_par_err", err_seen, 1);
    check("t3_par_ready", ready, 1'b0);
    send_bits(mk(8'h1C, 2), 11, 10);
    repeat (5) @(negedge clk);
    check("t3_stop_err", err_seen, 2);
    check("t3_stop_ready", ready, 1'b0);

    // Overflow with nine frames, then drain eight
    for (int i = 1; i <= 9; i++) send_bits(mk(8'(i), 0), 11, 10);
    repeat (5) @(negedge clk);
    check("t4_overflow", overflow, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      check("t4_drain", data, i);
      do_pop();
    end
    check("t4_empty", ready, 1'b0);
    check("t4_sticky", overflow, 1'b1);

    // Timeout after five bits, then recovery
    err_seen = 0;
    send_bits(mk(8'h5A, 0), 5, 10);
    repeat (TO + 20) @(negedge clk);
    check("t5_timeout_err", err_seen, 1);
    send_bits(mk(8'h5A, 0), 11, 10);
    repeat (5) @(negedge clk);
    check("t5_data", data, 8'h5A);
    do_pop();

    // Reset mid-frame and with bytes queued
    send_bits(mk(8'h77, 0), 7, 10);
    pulse_rst();
    for (int i = 0; i < 3; i++) send_bits(mk(8'h30 + 8'(i), 0), 11, 10);
    repeat (5) @(negedge clk);
    check("t6_queued", ready, 1'b1);
    pulse_rst();
    send_bits(mk(8'h29, 0), 11, 10);
    repeat (5) @(negedge clk);
    check("t6_data", data, 8'h29);
    check("t6_ready", ready, 1'b1);

    // Randomized traffic with random pops
    rnd_pop = 1'b1;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 19);
      hp   = $urandom_range(SS + 1, 12);
      b    = 8'($urandom_range(0, 255));
      if (kind == 3) begin
        send_bits(mk(b, 0), $urandom_range(1, 10), hp);
        repeat (TO + 5) @(negedge clk);
      end else begin
        send_bits(mk(b, (kind < 3) ? kind + 1 : 0), 11, hp);
      end
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    repeat (100) @(negedge clk);
    rnd_pop = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
